div_engine: RTL and testbench
=============================

# div_engine

Hardware divide responder for the start/done task protocol. It waits for a `start` pulse, then reads its operands byte-wise from data memory. It computes either the rounded 16-bit reciprocal (mode 0) or the rounded 24-bit fixed-point quotient of a 16-bit by 8-bit divide (mode 1). It writes the result bytes back to data memory and raises `done`. It sits between the sequencer/bench that issues `start` and the byte-wide data memory.

## Interface
- No parameters; addresses and widths are fixed.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst_n`  in  1  reset: synchronous, active-low.
- `start`  in  1  request: level high while the requester loads operands; the operation launches when it drops.
- `mode`  in  1  0 = reciprocal, 1 = 16/8 divide; sampled at launch.
- `done`  out  1  completion flag, registered.
- `busy`  out  1  high from launch until `done` rises.
- `mem_addr`  out  8  byte address to data memory.
- `mem_rd_data`  in  8  read data; memory read is combinational from `mem_addr`.
- `mem_wr_en`  out  1  write strobe; memory writes at the rising edge.
- `mem_wr_data`  out  8  write data.

## Operation
- States: IDLE, ARMED, LOAD, DIVIDE, ROUND, STORE.
- IDLE: reset state.
  - `start`=1 → ARMED, and `done` clears.
- ARMED:
  - `start`=0 → LOAD; `mode` is latched and `busy` is set.
  - `start`=1 → stay in ARMED.
- LOAD: one byte per cycle, with `mem_addr` driven and the byte captured at the edge.
  - Mode 0: addr 8 → divisor[15:8], addr 9 → divisor[7:0].
  - Mode 1: addr 0 → dividend[15:8], addr 1 → dividend[7:0], addr 2 → divisor[7:0].
- After the last byte: divisor == 0 → ROUND with quotient forced to all ones; otherwise → DIVIDE.
- DIVIDE: restoring division, one quotient bit per cycle, MSB first.
  - Mode 0: numerator 2^16, 17 iterations → 17-bit Q.
  - Mode 1: numerator dividend<<9, 25 iterations → 25-bit Q.
  - Partial remainder is 17 bits.
- ROUND: R = (Q+1)>>1.
  - Mode 0 keeps R[15:0]; mode 1 keeps R[23:0].
  - Equivalent to half-LSB upward rounding of round(2^15/d) and round(dividend·2^8/d).
  - Divide-by-zero result: 0xFFFF (mode 0), 0xFFFFFF (mode 1).
- STORE: one byte per cycle with `mem_wr_en`=1.
  - Mode 0: addr 10 ← R[15:8], addr 11 ← R[7:0].
  - Mode 1: addr 4 ← R[23:16], addr 5 ← R[15:8], addr 6 ← R[7:0].
- After the last write → IDLE with `done`=1 and `busy`=0; `done` holds until `start` is next sampled high.
- `start` is ignored while in LOAD, DIVIDE, ROUND or STORE.

## Timing
- Reset values: `done`=0, `busy`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0; state = IDLE.
- `rst_n` low at any edge, including mid-operation, returns the block to reset values.
  - A STORE in progress is abandoned; no further writes occur.
- Latency is counted from the edge at which ARMED samples `start`=0 (edge 0) to the edge at which `done` becomes 1.
  - Mode 0: 22 edges (LOAD 2 + DIVIDE 17 + ROUND 1 + STORE 2).
  - Mode 1: 32 edges (3 + 25 + 1 + 3).
  - Divide by zero: mode 0 takes 5 edges, mode 1 takes 7 edges.
- `mem_wr_en` is high only in STORE cycles, never in LOAD.
- Minimum `start` high time is one cycle.
- `done` is never high while `busy` is high.

## Configuration
- `DIV_ROUND_EN` defined: ROUND applies (Q+1)>>1 as above.
- `DIV_ROUND_EN` undefined: ROUND truncates, R = Q>>1.
  - Latency is unchanged.
  - The divide-by-zero all-ones result is unchanged.

## Test plan
- Mode 0, divisor 0x0003 → mem[10]=0x2A, mem[11]=0xAB; `done` at edge 22.
- Mode 0, divisor 0x0001 → 0x8000; divisor 0x0000 → 0xFFFF with `done` at edge 5.
- Mode 1, dividend 0x0001, divisor 0x03 → mem[4..6]=00 00 55; `done` at edge 32.
- Mode 1, dividend 0xFFFF, divisor 0x01 → FF FF 00; divisor 0x00 → FF FF FF with `done` at edge 7.
- `rst_n` low for one cycle at edge 10 of a mode 0 run → `done`=0, `busy`=0, no writes to mem[10]/mem[11]; a following run completes correctly.
- Without `DIV_ROUND_EN`, mode 0, divisor 3 → 0x2AAA.

Source files
------------

// File: rtl/div_engine.sv
// rtl/div_engine.sv - start/done divide responder: 16-bit reciprocal or 16/8 fixed-point quotient
// DIV_ROUND_EN defined: half-LSB upward rounding of the quotient; undefined: truncation.
module div_engine (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       mode,
  output logic       done,
  output logic       busy,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
);

  typedef enum logic [2:0] {
    S_IDLE, S_ARMED, S_LOAD, S_DIVIDE, S_ROUND, S_STORE
  } state_t;

  state_t      state_q, state_d;
  logic        mode_q, mode_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [24:0] num_q, num_d;
  logic [16:0] rem_q, rem_d;
  logic [24:0] quo_q, quo_d;
  logic [15:0] dvs_q, dvs_d;
  logic [23:0] res_q, res_d;

  logic [17:0] rem_sh;
  logic        rem_ge;
  logic        last_io;
  logic        last_div;

  assign done = done_q;
  assign busy = busy_q;

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    done_d      = done_q;
    busy_d      = busy_q;
    cnt_d       = cnt_q;
    num_d       = num_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    res_d       = res_q;
    mem_addr    = 8'd0;
    mem_wr_en   = 1'b0;
    mem_wr_data = 8'd0;

    // Numerator bits stream out of num_q MSB first into the partial remainder.
    rem_sh   = {rem_q, num_q[24]};
    rem_ge   = rem_sh >= {2'b00, dvs_q};
    last_io  = mode_q ? (cnt_q == 5'd2) : (cnt_q == 5'd1);
    last_div = mode_q ? (cnt_q == 5'd24) : (cnt_q == 5'd16);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ARMED;
          done_d  = 1'b0;
        end
      end
      S_ARMED: begin
        if (!start) begin
          state_d = S_LOAD;
          mode_d  = mode;
          busy_d  = 1'b1;
          cnt_d   = 5'd0;
          num_d   = mode ? 25'd0 : {17'h10000, 8'h00};
          rem_d   = 17'd0;
          quo_d   = 25'd0;
          dvs_d   = 16'd0;
        end
      end
      S_LOAD: begin
        mem_addr = (mode_q ? 8'd0 : 8'd8) + {3'b000, cnt_q};
        cnt_d    = cnt_q + 5'd1;
        if (mode_q) begin
          case (cnt_q)
            5'd0:    num_d[24:17] = mem_rd_data;
            5'd1:    num_d[16:9]  = mem_rd_data;
            default: dvs_d        = {8'h00, mem_rd_data};
          endcase
        end else begin
          if (cnt_q == 5'd0) dvs_d[15:8] = mem_rd_data;
          else               dvs_d[7:0]  = mem_rd_data;
        end
        if (last_io) begin
          cnt_d = 5'd0;
          if ((mode_q && mem_rd_data == 8'd0) ||
              (!mode_q && {dvs_q[15:8], mem_rd_data} == 16'd0)) begin
            quo_d   = '1;
            state_d = S_ROUND;
          end else begin
            state_d = S_DIVIDE;
          end
        end
      end
      S_DIVIDE: begin
        rem_d = rem_ge ? (rem_sh[16:0] - {1'b0, dvs_q}) : rem_sh[16:0];
        quo_d = {quo_q[23:0], rem_ge};
        num_d = {num_q[23:0], 1'b0};
        cnt_d = cnt_q + 5'd1;
        if (last_div) begin
          cnt_d   = 5'd0;
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        // A zero divisor always yields all ones, whatever the rounding option.
        if (dvs_q == 16'd0) begin
          res_d = '1;
        end else begin
`ifdef DIV_ROUND_EN
          res_d = quo_q[24:1] + {23'd0, quo_q[0]};
`else
          res_d = quo_q[24:1];
`endif
        end
        state_d = S_STORE;
      end
      S_STORE: begin
        mem_wr_en = 1'b1;
        mem_addr  = (mode_q ? 8'd4 : 8'd10) + {3'b000, cnt_q};
        if (mode_q) begin
          case (cnt_q)
            5'd0:    mem_wr_data = res_q[23:16];
            5'd1:    mem_wr_data = res_q[15:8];
            default: mem_wr_data = res_q[7:0];
          endcase
        end else begin
          mem_wr_data = (cnt_q == 5'd0) ? res_q[15:8] : res_q[7:0];
        end
        cnt_d = cnt_q + 5'd1;
        if (last_io) begin
          cnt_d   = 5'd0;
          state_d = S_IDLE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mode_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= 5'd0;
      num_q   <= 25'd0;
      rem_q   <= 17'd0;
      quo_q   <= 25'd0;
      dvs_q   <= 16'd0;
      res_q   <= 24'd0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      res_q   <= res_d;
    end
  end

endmodule

// File: tb/tb_div_engine.sv
// tb/tb_div_engine.sv - randomized self-checking bench for div_engine against an arithmetic model
module tb_div_engine;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       mode = 1'b0;
  logic       done, busy;
  logic [7:0] mem_addr;
  logic [7:0] mem_rd_data;
  logic       mem_wr_en;
  logic [7:0] mem_wr_data;

  logic [7:0] mem [0:255];
  int         wr_cnt [0:255];
  int         tests_run = 0;
  int         tests_failed = 0;

  div_engine dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode),
    .done(done), .busy(busy),
    .mem_addr(mem_addr), .mem_rd_data(mem_rd_data),
    .mem_wr_en(mem_wr_en), .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_wr_en) begin
      mem[mem_addr] <= mem_wr_data;
      wr_cnt[mem_addr] <= wr_cnt[mem_addr] + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] model(input logic m, input logic [15:0] dvd, input logic [15:0] dvs);
    longint n, d;
    d = m ? longint'(dvs[7:0]) : longint'(dvs);
    n = longint'(dvd);
    if (d == 0) return m ? 24'hFFFFFF : 24'h00FFFF;
`ifdef DIV_ROUND_EN
    if (m) return 24'((n * 512 + d) / (2 * d));
    else   return 24'((65536 + d) / (2 * d));
`else
    if (m) return 24'((n * 256) / d);
    else   return 24'(32768 / d);
`endif
  endfunction

  task automatic clear_wr();
    for (int a = 0; a < 256; a++) wr_cnt[a] = 0;
  endtask

  task automatic launch(input logic m, input logic [15:0] dvd, input logic [15:0] dvs,
                        input logic [23:0] exp);
    if (m) begin
      mem[0] = dvd[15:8]; mem[1] = dvd[7:0]; mem[2] = dvs[7:0];
      mem[4] = ~exp[23:16]; mem[5] = ~exp[15:8]; mem[6] = ~exp[7:0];
    end else begin
      mem[8] = dvs[15:8]; mem[9] = dvs[7:0];
      mem[10] = ~exp[15:8]; mem[11] = ~exp[7:0];
    end
    clear_wr();
    @(posedge clk); #1;
    start = 1'b1;
    mode  = m;
    repeat ($urandom_range(1, 3)) @(posedge clk);
    #1;
    check("done_cleared", {31'd0, done}, 32'd0);
    start = 1'b0;
    @(posedge clk); #1;
    mode = ~m;
    check("busy_at_launch", {31'd0, busy}, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic m, input logic [15:0] dvd, input logic [15:0] dvs);
    logic [23:0] exp, got;
    int exp_lat, lat, viol, tot;
    bit zero;
    zero = m ? (dvs[7:0] == 8'd0) : (dvs == 16'd0);
    exp = model(m, dvd, dvs);
    exp_lat = m ? (zero ? 7 : 32) : (zero ? 5 : 22);
    launch(m, dvd, dvs, exp);
    lat = 0;
    viol = 0;
    for (int n = 1; n <= 60; n++) begin
      start = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      if (done && busy) viol++;
      if (!done && !busy) viol++;
      if (done) begin
        lat = n;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_done_overlap"}, viol, 0);
    check({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
    got = m ? {mem[4], mem[5], mem[6]} : {8'h00, mem[10], mem[11]};
    check({tag, "_result"}, {8'd0, got}, {8'd0, exp});
    tot = 0;
    for (int a = 0; a < 256; a++) tot += wr_cnt[a];
    check({tag, "_write_count"}, tot, m ? 3 : 2);
  endtask

  initial begin
    logic m;
    logic [15:0] dvd, dvs;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    clear_wr();
    repeat (3) @(posedge clk);
    #1;
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("reset_addr", {24'd0, mem_addr}, 32'd0);
    check("reset_wr_data", {24'd0, mem_wr_data}, 32'd0);
    rst_n = 1'b1;

    run_op("m0_d3", 1'b0, 16'h0000, 16'h0003);
    run_op("m0_d1", 1'b0, 16'h0000, 16'h0001);
    run_op("m0_d0", 1'b0, 16'h0000, 16'h0000);
    run_op("m0_dffff", 1'b0, 16'h0000, 16'hFFFF);
    run_op("m1_1_3", 1'b1, 16'h0001, 16'h0003);
    run_op("m1_ffff_1", 1'b1, 16'hFFFF, 16'h0001);
    run_op("m1_div0", 1'b1, 16'h1234, 16'h0000);

    // Reset pulse at edge 10 of a mode 0 run must abandon it without any result writes.
    launch(1'b0, 16'h0000, 16'h0003, model(1'b0, 16'h0000, 16'h0003));
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid_done", {31'd0, done}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_wr_en", {31'd0, mem_wr_en}, 32'd0);
    check("rst_mid_addr", {24'd0, mem_addr}, 32'd0);
    repeat (30) @(posedge clk);
    #1;
    check("rst_mid_no_writes", wr_cnt[10] + wr_cnt[11], 0);
    run_op("after_rst", 1'b0, 16'h0000, 16'h0003);

    for (int i = 0; i < 20; i++) begin
      m = 1'($urandom_range(0, 1));
      dvd = 16'($urandom);
      dvs = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      if (m && dvs[7:0] == 8'd0 && dvs != 16'h0000) dvs[0] = 1'b1;
      run_op("rand", m, dvd, dvs);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
